// File: rtl/gpio_bus_initiator_if.sv
// Command, response and register-bus signals of the GPIO/ADC/touch register-bank initiator.
// master is the initiator's view; slave is the command source plus register-bank view.
interface gpio_bus_initiator_if #(
   parameter int AddrWidth = 16,
   parameter int BusWidth  = 32,
   parameter int FifoDepth = 4
);
   localparam int LevelWidth = $clog2(FifoDepth) + 1;

   logic                    cmd_valid;
   logic                    cmd_ready;
   logic                    cmd_write;
   logic [AddrWidth-3:0]    cmd_addr;
   logic [BusWidth-1:0]     cmd_wdata;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [BusWidth-1:0]     rsp_data;
   logic                    chip_sel;
   logic                    write_reg;
   logic                    read_reg;
   logic [AddrWidth-3:0]    busaddress;
   logic [BusWidth-1:0]     busdata_out;
   logic [BusWidth-1:0]     busdata_in;
   logic                    busy;
   logic [LevelWidth-1:0]   cmd_level;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, busdata_in,
      output cmd_ready, rsp_valid, rsp_data, chip_sel, write_reg, read_reg,
             busaddress, busdata_out, busy, cmd_level
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, busdata_in,
      input  cmd_ready, rsp_valid, rsp_data, chip_sel, write_reg, read_reg,
             busaddress, busdata_out, busy, cmd_level
   );
endinterface

// File: rtl/gpio_bus_initiator.sv
// Register-bank bus master: queued read/write commands become timed chip_sel/strobe cycles,
// read data lands in a single-entry response register.
module gpio_bus_initiator #(
   parameter int AddrWidth    = 16,
   parameter int BusWidth     = 32,
   parameter int FifoDepth    = 4,
   parameter int StrobeCycles = 2,
   parameter int ReadLatency  = 4,
   parameter int GapCycles    = 1
) (
   input  logic                 reg_clk,
   input  logic                 reset_in,
   gpio_bus_initiator_if.master bus
);
   localparam int AW     = AddrWidth - 2;
   localparam int PW     = $clog2(FifoDepth);
   localparam int LW     = PW + 1;
   localparam int MaxSR  = (StrobeCycles > ReadLatency) ? StrobeCycles : ReadLatency;
   localparam int MaxCnt = (MaxSR > GapCycles) ? MaxSR : GapCycles;
   localparam int CW     = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETUP  = 3'd1;
   localparam logic [2:0] ST_STROBE = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_HOLD   = 3'd4;

   typedef struct packed {
      logic                write;
      logic [AW-1:0]       addr;
      logic [BusWidth-1:0] wdata;
   } cmd_t;

   cmd_t                fifo_mem [FifoDepth];
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [LW-1:0]       level;
   cmd_t                head;
   logic                push, pop;

   logic [2:0]          state;
   logic [CW-1:0]       cnt;
   logic                is_write;
   logic                chip_sel_q, write_q, read_q, busy_q;
   logic [AW-1:0]       addr_q;
   logic [BusWidth-1:0] wdata_q;
   logic                rsp_valid_q;
   logic [BusWidth-1:0] rsp_data_q;

   assign head = fifo_mem[rd_ptr];
   assign push = bus.cmd_valid & bus.cmd_ready;
   // Writes may overtake a pending response; reads wait until it is consumed.
   assign pop  = (state == ST_IDLE) && (level != '0) && (head.write || !rsp_valid_q);

   always_ff @(posedge reg_clk) begin
      if (push) fifo_mem[wr_ptr] <= '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
   end

   always_ff @(posedge reg_clk or posedge reset_in) begin
      if (reset_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge reg_clk or posedge reset_in) begin
      if (reset_in) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         is_write    <= 1'b0;
         chip_sel_q  <= 1'b0;
         write_q     <= 1'b0;
         read_q      <= 1'b0;
         busy_q      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         if (rsp_valid_q && bus.rsp_ready) rsp_valid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               // chip_sel stays up across back-to-back commands, drops after one idle cycle
               if (pop) begin
                  state      <= ST_SETUP;
                  busy_q     <= 1'b1;
                  chip_sel_q <= 1'b1;
                  is_write   <= head.write;
                  addr_q     <= head.addr;
                  if (head.write) wdata_q <= head.wdata;
               end else begin
                  chip_sel_q <= 1'b0;
               end
            end
            ST_SETUP: begin
               state   <= ST_STROBE;
               cnt     <= CW'(StrobeCycles - 1);
               write_q <= is_write;
               read_q  <= !is_write;
            end
            ST_STROBE: begin
               if (cnt == '0) begin
                  write_q <= 1'b0;
                  read_q  <= 1'b0;
                  if (is_write) begin
                     state <= ST_HOLD;
                     cnt   <= CW'(GapCycles - 1);
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= CW'(ReadLatency - 1);
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  rsp_data_q  <= bus.busdata_in;
                  rsp_valid_q <= 1'b1;
                  state       <= ST_HOLD;
                  cnt         <= CW'(GapCycles - 1);
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            ST_HOLD: begin
               if (cnt == '0) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state      <= ST_IDLE;
               busy_q     <= 1'b0;
               chip_sel_q <= 1'b0;
               write_q    <= 1'b0;
               read_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmd_ready   = (level != LW'(FifoDepth));
   assign bus.cmd_level   = level;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.chip_sel    = chip_sel_q;
   assign bus.write_reg   = write_q;
   assign bus.read_reg    = read_q;
   assign bus.busaddress  = addr_q;
   assign bus.busdata_out = wdata_q;
   assign bus.busy        = busy_q;
endmodule

// File: tb/tb_gpio_bus_initiator.sv
// Directed bench for gpio_bus_initiator: expected bus cycles and responses are queued at issue
// and a negedge monitor matches them against what the DUT drives.
module tb_gpio_bus_initiator;
   localparam int AW = 14;
   localparam int BW = 32;
   localparam int SC = 2;

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [BW-1:0] data;
      int            rise;
   } bus_exp_t;

   typedef struct {
      logic [BW-1:0] data;
      int            rise;
   } rsp_exp_t;

   logic reg_clk  = 1'b0;
   logic reset_in = 1'b1;
   int   cyc      = 0;
   int   total    = 0;
   int   bad      = 0;

   bus_exp_t exp_bus [$];
   rsp_exp_t exp_rsp [$];

   gpio_bus_initiator_if #(.AddrWidth(16), .BusWidth(BW), .FifoDepth(4)) bus ();

   gpio_bus_initiator #(
      .AddrWidth(16), .BusWidth(BW), .FifoDepth(4),
      .StrobeCycles(SC), .ReadLatency(4), .GapCycles(1)
   ) dut (
      .reg_clk  (reg_clk),
      .reset_in (reset_in),
      .bus      (bus)
   );

   always #5 reg_clk = ~reg_clk;
   always @(posedge reg_clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [BW-1:0] slv_data(input logic [AW-1:0] a);
      return {16'hA5A5, 2'b00, a};
   endfunction

   // Register-bank model: read data becomes valid four cycles after the read strobe rises.
   int scnt = 0;
   bit spr  = 1'b0;
   always @(negedge reg_clk) begin
      if (reset_in) begin
         scnt = 0;
         bus.busdata_in = '0;
      end else if (bus.read_reg && !spr) begin
         bus.busdata_in = 32'hDEADBEEF;
         scnt = 4;
      end else if (scnt > 0) begin
         scnt--;
         if (scnt == 0) bus.busdata_in = slv_data(bus.busaddress);
      end
      spr = bus.read_reg;
   end

   // Monitor: strobe rises and response rises pop the scoreboard queues.
   bit       pw = 1'b0, pr = 1'b0, prv = 1'b0;
   int       wcnt = 0;
   bus_exp_t cur;
   rsp_exp_t re;
   always @(negedge reg_clk) begin
      logic strobe, pstrobe;
      strobe  = bus.write_reg | bus.read_reg;
      pstrobe = pw | pr;
      if (strobe && !pstrobe) begin
         if (exp_bus.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got wr=%0b addr=%0h expected none", bus.write_reg, bus.busaddress);
         end else begin
            cur = exp_bus.pop_front();
            check("strobe_kind", bus.write_reg, cur.wr);
            check("one_strobe", bus.write_reg & bus.read_reg, 0);
            check("strobe_cs", bus.chip_sel, 1);
            check("strobe_addr", bus.busaddress, cur.addr);
            if (cur.wr) check("strobe_wdata", bus.busdata_out, cur.data);
            else        check("read_no_pending_rsp", bus.rsp_valid, 0);
            if (cur.rise >= 0) check("strobe_cycle", cyc, cur.rise);
         end
         wcnt = 1;
      end else if (strobe) begin
         wcnt++;
      end else if (pstrobe && !reset_in) begin
         check("strobe_width", wcnt, SC);
         check("addr_held", bus.busaddress, cur.addr);
         if (cur.wr) check("wdata_held", bus.busdata_out, cur.data);
      end
      if (bus.rsp_valid && !prv) begin
         if (exp_rsp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got %0h expected none", bus.rsp_data);
         end else begin
            re = exp_rsp.pop_front();
            check("rsp_data", bus.rsp_data, re.data);
            if (re.rise >= 0) check("rsp_cycle", cyc, re.rise);
         end
      end
      pw  = bus.write_reg;
      pr  = bus.read_reg;
      prv = bus.rsp_valid;
   end

   task automatic push(input bit w, input logic [AW-1:0] a, input logic [BW-1:0] d, output int t);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      for (int i = 0; i < 60 && !bus.cmd_ready; i++) @(negedge reg_clk);
      if (!bus.cmd_ready) begin
         total++;
         bad++;
         $display("FAIL push_timeout: got cmd_ready=0 expected 1");
      end
      @(posedge reg_clk);
      @(negedge reg_clk);
      t = cyc;
   endtask

   task automatic wait_quiet();
      int i;
      for (i = 0; i < 200; i++) begin
         if (!bus.busy && bus.cmd_level == 0 && !bus.chip_sel) break;
         @(negedge reg_clk);
      end
      if (i == 200) begin
         total++;
         bad++;
         $display("FAIL quiet_timeout: got busy=%0b level=%0d expected idle", bus.busy, bus.cmd_level);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, base, i;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;

      // reset values
      @(negedge reg_clk);
      @(negedge reg_clk);
      check("rst_cs", bus.chip_sel, 0);
      check("rst_wr", bus.write_reg, 0);
      check("rst_rd", bus.read_reg, 0);
      check("rst_rv", bus.rsp_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_addr", bus.busaddress, 0);
      check("rst_wdata", bus.busdata_out, 0);
      check("rst_rdata", bus.rsp_data, 0);
      check("rst_level", bus.cmd_level, 0);
      check("rst_ready", bus.cmd_ready, 1);
      reset_in = 1'b0;
      repeat (5) @(negedge reg_clk);
      check("idle_cs", bus.chip_sel, 0);
      check("idle_busy", bus.busy, 0);

      // single write
      push(1'b1, 14'h0440, 32'h00FFF000, t);
      bus.cmd_valid = 1'b0;
      exp_bus.push_back('{1'b1, 14'h0440, 32'h00FFF000, t + 2});
      check("wr_cs_T", bus.chip_sel, 0);
      @(negedge reg_clk);
      check("wr_cs_T1", bus.chip_sel, 1);
      check("wr_busy_T1", bus.busy, 1);
      repeat (4) @(negedge reg_clk);
      check("wr_cs_T5", bus.chip_sel, 1);
      @(negedge reg_clk);
      check("wr_cs_T6", bus.chip_sel, 0);
      check("wr_busy_T6", bus.busy, 0);

      // single read
      push(1'b0, 14'h0042, 32'h0, t);
      bus.cmd_valid = 1'b0;
      exp_bus.push_back('{1'b0, 14'h0042, 32'h0, t + 2});
      exp_rsp.push_back('{32'hA5A50042, t + 8});
      repeat (10) @(negedge reg_clk);
      check("rd_pending", bus.rsp_valid, 1);
      bus.rsp_ready = 1'b1;
      @(negedge reg_clk);
      bus.rsp_ready = 1'b0;
      check("rd_cleared", bus.rsp_valid, 0);
      check("rd_data_held", bus.rsp_data, 32'hA5A50042);
      wait_quiet();

      // FIFO full from reset: six back-to-back writes, the sixth stalls
      reset_in = 1'b1;
      @(negedge reg_clk);
      reset_in = 1'b0;
      @(negedge reg_clk);
      base = 0;
      for (i = 0; i < 6; i++) begin
         push(1'b1, 14'h0100 + 14'(i), 32'h11110000 + 32'(i), t);
         if (i == 0) base = t;
         exp_bus.push_back('{1'b1, 14'h0100 + 14'(i), 32'h11110000 + 32'(i), base + 2 + 5 * i});
         if (i == 4) begin
            check("full_level", bus.cmd_level, 4);
            check("full_ready", bus.cmd_ready, 0);
         end
         if (i == 5) check("stall_accept", t, base + 7);
      end
      bus.cmd_valid = 1'b0;
      wait_quiet();

      // response backpressure: read, write, read with rsp_ready low
      push(1'b0, 14'h0010, 32'h0, t);
      exp_bus.push_back('{1'b0, 14'h0010, 32'h0, -1});
      exp_rsp.push_back('{32'hA5A50010, -1});
      push(1'b1, 14'h0020, 32'hCAFE0020, t);
      exp_bus.push_back('{1'b1, 14'h0020, 32'hCAFE0020, -1});
      push(1'b0, 14'h0030, 32'h0, t);
      exp_bus.push_back('{1'b0, 14'h0030, 32'h0, -1});
      exp_rsp.push_back('{32'hA5A50030, -1});
      bus.cmd_valid = 1'b0;
      for (i = 0; i < 40 && !bus.write_reg; i++) @(negedge reg_clk);
      check("bp_write_seen", bus.write_reg, 1);
      check("bp_write_with_rsp", bus.rsp_valid, 1);
      repeat (10) @(negedge reg_clk);
      check("bp_read_held_cs", bus.chip_sel, 0);
      check("bp_read_held_busy", bus.busy, 0);
      check("bp_read_held_level", bus.cmd_level, 1);
      bus.rsp_ready = 1'b1;
      @(negedge reg_clk);
      bus.rsp_ready = 1'b0;
      for (i = 0; i < 40 && !bus.rsp_valid; i++) @(negedge reg_clk);
      check("bp_second_rsp", bus.rsp_valid, 1);
      bus.rsp_ready = 1'b1;
      @(negedge reg_clk);
      bus.rsp_ready = 1'b0;
      wait_quiet();

      // reset during the first strobe cycle of a read, two commands queued behind it
      push(1'b0, 14'h0050, 32'h0, t);
      exp_bus.push_back('{1'b0, 14'h0050, 32'h0, t + 2});
      push(1'b1, 14'h0060, 32'h60606060, t);
      push(1'b1, 14'h0070, 32'h70707070, t);
      bus.cmd_valid = 1'b0;
      check("mid_read_strobe", bus.read_reg, 1);
      check("mid_level", bus.cmd_level, 2);
      #1 reset_in = 1'b1;
      #1;
      check("async_rd_drop", bus.read_reg, 0);
      check("async_cs_drop", bus.chip_sel, 0);
      check("async_level", bus.cmd_level, 0);
      check("async_busy", bus.busy, 0);
      @(negedge reg_clk);
      @(negedge reg_clk);
      reset_in = 1'b0;
      repeat (15) @(negedge reg_clk);
      check("no_rsp_after_rst", bus.rsp_valid, 0);
      check("no_bus_after_rst", bus.chip_sel, 0);

      check("bus_queue_empty", exp_bus.size(), 0);
      check("rsp_queue_empty", exp_rsp.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
